// File: rtl/lcd_serial_mux_if.sv
// Select/scan port bundle for lcd_serial_mux: sequencer-side controls and registered bit outputs.
interface lcd_serial_mux_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = $clog2(WIDTH)
);
    logic             en;
    logic             mode;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [SEL_W-1:0] sel;
    logic             data_out;
    logic             busy;
    logic             done;
    logic [SEL_W-1:0] bit_idx;

    modport master (
        output en, mode, start, data_in, sel,
        input  data_out, busy, done, bit_idx
    );

    modport slave (
        input  en, mode, start, data_in, sel,
        output data_out, busy, done, bit_idx
    );
endinterface

// File: rtl/lcd_serial_mux.sv
// Registered bit selector (mode 0) and shadow-register serializer (mode 1) for the LCD datapath.
module lcd_serial_mux #(
    parameter int WIDTH     = 32,
    parameter int SEL_W     = $clog2(WIDTH),
    parameter int MSB_FIRST = 0
) (
    input logic             clk,
    input logic             rst,
    lcd_serial_mux_if.slave bus
);
    localparam logic [SEL_W-1:0] FIRST = (MSB_FIRST != 0) ? SEL_W'(WIDTH - 1) : '0;
    localparam logic [SEL_W-1:0] LAST  = (MSB_FIRST != 0) ? '0 : SEL_W'(WIDTH - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shadow, shadow_nxt;
    logic             dout, dout_nxt;
    logic             done, done_nxt;
    logic [SEL_W-1:0] idx, idx_nxt;
    logic [SEL_W-1:0] step_idx;
    logic             sel_bit;

    // Out-of-range selects only exist when WIDTH is not a power of two.
    always_comb begin
        sel_bit = 1'b0;
        if (int'(bus.sel) < WIDTH)
            sel_bit = bus.data_in[bus.sel];
    end

    always_comb begin
        step_idx = (MSB_FIRST != 0) ? idx - SEL_W'(1) : idx + SEL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shadow <= '0;
            dout   <= 1'b0;
            done   <= 1'b0;
            idx    <= '0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            dout   <= dout_nxt;
            done   <= done_nxt;
            idx    <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        dout_nxt   = dout;
        done_nxt   = done;
        idx_nxt    = idx;
        if (bus.en) begin
            case (state)
                IDLE: begin
                    done_nxt = 1'b0;
                    if (!bus.mode) begin
                        dout_nxt = sel_bit;
                        idx_nxt  = bus.sel;
                    end else if (bus.start) begin
                        state_nxt  = SCAN;
                        shadow_nxt = bus.data_in;
                        dout_nxt   = bus.data_in[FIRST];
                        idx_nxt    = FIRST;
                    end else begin
                        dout_nxt = 1'b0;
                    end
                end
                SCAN: begin
                    if (idx != LAST) begin
                        idx_nxt  = step_idx;
                        dout_nxt = shadow[step_idx];
                        done_nxt = (step_idx == LAST);
                    end else if (bus.start && bus.mode) begin
                        // Recapture in the done cycle keeps the stream gap-free.
                        shadow_nxt = bus.data_in;
                        dout_nxt   = bus.data_in[FIRST];
                        idx_nxt    = FIRST;
                        done_nxt   = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        dout_nxt  = 1'b0;
                        done_nxt  = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.data_out = dout;
    assign bus.done     = done;
    assign bus.bit_idx  = idx;
    assign bus.busy     = (state == SCAN);
endmodule
